// File: rtl/alu_div_seq.sv
// Iterative radix-2 restoring divider (DIV/DIVU) with start/busy/done handshake.
// Optional macro ALU_DIV_EARLY_OUT_EN: finish in one edge when |A| < |B|.
module alu_div_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             Sign,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             Z,
    output logic             V,
    output logic             N,
    output logic             DZ
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic             aneg_q, aneg_d;
    logic             sgn_q, sgn_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             z_q, z_d, v_q, v_d, n_q, n_d, dz_q, dz_d;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic             b_zero, early;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic [WIDTH-1:0] q_fin, r_fin;

    assign a_mag  = (Sign && A[WIDTH-1]) ? -A : A;
    assign b_mag  = (Sign && B[WIDTH-1]) ? -B : B;
    assign b_zero = (B == '0);

`ifdef ALU_DIV_EARLY_OUT_EN
    assign early = (a_mag < b_mag);
`else
    assign early = 1'b0;
`endif

    // Dividend bits shift out of dvd_q's MSB while quotient bits shift into its LSB.
    assign shifted = {rem_q, dvd_q[WIDTH-1]};
    assign trial   = {1'b0, shifted} - {2'b00, dsr_q};
    assign q_fin   = neg_q  ? -dvd_q : dvd_q;
    assign r_fin   = aneg_q ? -rem_q : rem_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (b_zero || early) state_d = S_DONE;
                    else                 state_d = S_CALC;
                end
            end
            S_CALC:  if (cnt_q == CW'(1)) state_d = S_FIX;
            S_FIX:   state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_CALC) || (state_q == S_FIX);
        done = (state_q == S_DONE);
    end

    always_comb begin
        dvd_d  = dvd_q;
        dsr_d  = dsr_q;
        rem_d  = rem_q;
        cnt_d  = cnt_q;
        neg_d  = neg_q;
        aneg_d = aneg_q;
        sgn_d  = sgn_q;
        q_d    = q_q;
        r_d    = r_q;
        z_d    = z_q;
        v_d    = v_q;
        n_d    = n_q;
        dz_d   = dz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (b_zero) begin
                        q_d  = '1;
                        r_d  = A;
                        z_d  = 1'b0;
                        v_d  = 1'b0;
                        n_d  = 1'b0;
                        dz_d = 1'b1;
                    end else if (early) begin
                        q_d  = '0;
                        r_d  = A;
                        z_d  = 1'b1;
                        v_d  = 1'b0;
                        n_d  = 1'b0;
                        dz_d = 1'b0;
                    end else begin
                        dvd_d  = a_mag;
                        dsr_d  = b_mag;
                        rem_d  = '0;
                        cnt_d  = CW'(WIDTH);
                        neg_d  = Sign & (A[WIDTH-1] ^ B[WIDTH-1]);
                        aneg_d = Sign & A[WIDTH-1];
                        sgn_d  = Sign;
                    end
                end
            end
            S_CALC: begin
                if (trial[WIDTH+1]) rem_d = shifted[WIDTH-1:0];
                else                rem_d = trial[WIDTH-1:0];
                dvd_d = {dvd_q[WIDTH-2:0], ~trial[WIDTH+1]};
                cnt_d = cnt_q - CW'(1);
            end
            S_FIX: begin
                q_d  = q_fin;
                r_d  = r_fin;
                z_d  = (q_fin == '0);
                // Only most-negative / -1 yields a positive magnitude with the MSB set.
                v_d  = sgn_q & ~neg_q & dvd_q[WIDTH-1];
                n_d  = neg_q & (dvd_q != '0);
                dz_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dvd_q  <= '0;
            dsr_q  <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            neg_q  <= 1'b0;
            aneg_q <= 1'b0;
            sgn_q  <= 1'b0;
            q_q    <= '0;
            r_q    <= '0;
            z_q    <= 1'b0;
            v_q    <= 1'b0;
            n_q    <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            dvd_q  <= dvd_d;
            dsr_q  <= dsr_d;
            rem_q  <= rem_d;
            cnt_q  <= cnt_d;
            neg_q  <= neg_d;
            aneg_q <= aneg_d;
            sgn_q  <= sgn_d;
            q_q    <= q_d;
            r_q    <= r_d;
            z_q    <= z_d;
            v_q    <= v_d;
            n_q    <= n_d;
            dz_q   <= dz_d;
        end
    end

    assign Q  = q_q;
    assign R  = r_q;
    assign Z  = z_q;
    assign V  = v_q;
    assign N  = n_q;
    assign DZ = dz_q;

endmodule

// File: tb/tb_alu_div_seq.sv
// Scoreboard bench for alu_div_seq: driver pushes expected results, monitor checks on done.
module tb_alu_div_seq;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         Sign = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         busy, done, Z, V, N, DZ;
    logic [W-1:0] Q, R;

    alu_div_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .Sign(Sign), .A(A), .B(B),
        .busy(busy), .done(done), .Q(Q), .R(R), .Z(Z), .V(V), .N(N), .DZ(DZ)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z, v, n, dz;
        int           lat;
        int           done_cyc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // Reference: plain 64-bit arithmetic; SV '/' truncates toward zero and '%' follows the dividend.
    function automatic exp_t model(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint sa, sb_, qq, rr, ma, mb;
        e.lat = W + 1;
        e.v = 1'b0; e.n = 1'b0; e.dz = 1'b0;
        if (b == '0) begin
            e.q = '1; e.r = a; e.z = 1'b0; e.dz = 1'b1; e.lat = 0;
            return e;
        end
        if (s) begin
            sa = longint'($signed(a));
            sb_ = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb_ = longint'({32'd0, b});
        end
        qq = sa / sb_;
        rr = sa % sb_;
        e.q = qq[W-1:0];
        e.r = rr[W-1:0];
        e.z = (e.q == '0);
        e.v = s && (qq > 64'sd2147483647);
        e.n = s && (qq < 0);
        ma = (sa < 0) ? -sa : sa;
        mb = (sb_ < 0) ? -sb_ : sb_;
`ifdef ALU_DIV_EARLY_OUT_EN
        if (ma < mb) e.lat = 0;
`else
        if (ma < mb) e.lat = W + 1;
`endif
        return e;
    endfunction

    // Monitor: every done sample must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (done) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_done at cycle %0d: got done=1, required no pending op", cyc);
                end else begin
                    e = sb.pop_front();
                    if ({Q, R, Z, V, N, DZ} !== {e.q, e.r, e.z, e.v, e.n, e.dz}) begin
                        fails++;
                        $display("FAIL result: got Q=%h R=%h Z%b V%b N%b DZ%b, required Q=%h R=%h Z%b V%b N%b DZ%b",
                                 Q, R, Z, V, N, DZ, e.q, e.r, e.z, e.v, e.n, e.dz);
                    end
                    tests++;
                    if (cyc != e.done_cyc) begin
                        fails++;
                        $display("FAIL latency: done at edge %0d, required edge %0d", cyc, e.done_cyc);
                    end
                end
            end
        end
    end

    // Assumes the caller is at posedge+1 with the DUT idle.
    task automatic run_op(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit poke_busy, input bit poke_done);
        exp_t e;
        int   waited, busy_cnt;
        e = model(s, a, b);
        e.done_cyc = cyc + 1 + e.lat;
        sb.push_back(e);
        Sign = s; A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = $urandom; B = $urandom | 32'h1; Sign = 1'($urandom);
        waited = 0; busy_cnt = 0;
        while (!done && waited < 200) begin
            if (busy) busy_cnt++;
            start = (poke_busy && waited == 5);
            @(posedge clk); #1;
            waited++;
        end
        start = 1'b0;
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL timeout: done not seen within 200 cycles for A=%h B=%h", a, b);
        end
        tests++;
        if (busy_cnt != e.lat) begin
            fails++;
            $display("FAIL busy_cycles: got %0d, required %0d", busy_cnt, e.lat);
        end
        if (poke_done) begin
            A = 32'd1000; B = 32'd3; start = 1'b1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        tests++;
        if (busy || done || Q !== e.q || R !== e.r) begin
            fails++;
            $display("FAIL idle_hold: got busy=%b done=%b Q=%h R=%h, required busy=0 done=0 Q=%h R=%h",
                     busy, done, Q, R, e.q, e.r);
        end
    endtask

    task automatic reset_abort();
        Sign = 1'b0; A = 32'd100; B = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        tests++;
        if ({busy, done, Q, R, Z, V, N, DZ} !== '0) begin
            fails++;
            $display("FAIL reset_abort: got busy=%b done=%b Q=%h R=%h Z%b V%b N%b DZ%b, required all 0",
                     busy, done, Q, R, Z, V, N, DZ);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        tests++;
        if (busy || Q !== '0) begin
            fails++;
            $display("FAIL post_reset_idle: got busy=%b Q=%h, required busy=0 Q=0", busy, Q);
        end
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        bit           rs;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({busy, done, Q, R, Z, V, N, DZ} !== '0) begin
            fails++;
            $display("FAIL reset_state: got busy=%b done=%b Q=%h R=%h, required all 0", busy, done, Q, R);
        end
        reset = 1'b0;
        @(posedge clk); #1;

        run_op(1'b0, 32'd100, 32'd7, 1'b0, 1'b0);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op(1'b0, 32'd5, 32'd0, 1'b0, 1'b0);
        run_op(1'b1, 32'd5, 32'd0, 1'b0, 1'b0);
        run_op(1'b0, 32'd9, 32'd3, 1'b0, 1'b0);
        reset_abort();
        run_op(1'b0, 32'd50, 32'd5, 1'b1, 1'b0);
        run_op(1'b0, 32'd3, 32'd10, 1'b0, 1'b1);
        run_op(1'b1, 32'h8000_0000, 32'd1, 1'b0, 1'b0);
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            rs = 1'($urandom);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: ;
                1: rb = 32'($urandom_range(1, 300));
                2: rb = '0;
                3: begin ra = 32'($urandom_range(0, 50)); rb = 32'($urandom_range(51, 5000)); end
                4: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                default: begin ra = -32'($urandom_range(1, 1000)); rb = 32'($urandom_range(1, 40)); end
            endcase
            run_op(rs, ra, rb, (i % 7) == 3, (i % 5) == 2);
        end

        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_div_seq.md
Name: alu_div_seq

Overview:
- Iterative radix-2 restoring divider: the inverse operation to the team's combinational adder, built from repeated subtraction.
- Sits beside the adder in the ALU and serves DIV/DIVU.
- Same Sign convention as the adder; returns quotient, remainder and Z/V/N flags plus divide-by-zero.
- Multi-cycle. Uses a start/busy/done handshake toward the pipeline stall logic.

Parameters:
WIDTH, 32, operand/quotient/remainder width in bits (must be >= 4)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high; forces IDLE and clears all outputs
start  in  1  request; sampled only in IDLE
Sign  in  1  1 = two's-complement operands, 0 = unsigned
A  in  WIDTH  dividend, sampled with start
B  in  WIDTH  divisor, sampled with start
busy  out  1  high in CALC and FIX
done  out  1  one-cycle pulse; Q/R/flags valid from this cycle on
Q  out  WIDTH  quotient
R  out  WIDTH  remainder
Z  out  1  Q == 0
V  out  1  signed overflow (Sign=1, A = most-negative, B = -1)
N  out  1  true quotient negative and nonzero (signed only)
DZ  out  1  divide by zero (B == 0)

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, Q, R, Z, V, N and DZ all 0. The in-flight operation is discarded with no done pulse.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1 with B==0:
  - next state DONE.
  - Q = all ones; R = A; DZ = 1; V = N = Z = 0.
  - done is high after 1 edge.
- IDLE, start=1 with B!=0:
  - latch |A| and |B| (magnitude taken only if Sign=1 and MSB=1), sign of A, and sign of A xor sign of B.
  - clear partial remainder; count = WIDTH; next state CALC.
  - Outputs Q/R/flags keep their old values until FIX.
- CALC, one bit per edge, MSB first:
  - shift the partial remainder left one bit, bringing in the next dividend bit.
  - trial-subtract |B| in WIDTH+1 bits. If non-negative, keep the difference and set the quotient bit to 1; otherwise restore and set it to 0.
  - decrement count; at count==1 go to FIX.
- FIX:
  - negate the quotient if the sign flag is set.
  - negate the remainder if the dividend was negative, so the remainder takes the dividend's sign.
  - register Q, R, Z, V, N; DZ = 0; next state DONE.
- DONE: done=1 for exactly one cycle, then IDLE. start in DONE is ignored.
- Latency for B!=0: done is high after edge WIDTH+2 counted from the start edge (34 for WIDTH=32). busy is high for WIDTH+1 cycles.
- Overflow: most-negative / -1 yields Q = 0x80000000, R = 0, V = 1, N = 0, Z = 0. This falls out of the magnitude path; no special casing.
- Sign=0: N = V = 0 always.
- start while busy or done is ignored. Operands are not re-sampled.
- Q/R/flags hold their values in IDLE until the next FIX or DZ completion.

Optional Feature:
- Macro ALU_DIV_EARLY_OUT_EN.
- Defined: in IDLE with B!=0 and |A| < |B| (includes A==0), go straight to DONE with Q=0, R=A, Z=1, V=N=DZ=0. done is high after 1 edge and busy never rises.
- Undefined: all B!=0 operations take the full WIDTH+2 latency.
- Values of Q, R and the flags are identical either way; only latency differs.

Test Plan:
- Sign=0, A=100, B=7, start one cycle -> done at edge 34; Q=14, R=2, Z=V=N=DZ=0; busy high 33 cycles.
- Sign=1, A=-7 (0xFFFFFFF9), B=2 -> Q=0xFFFFFFFD (-3), R=0xFFFFFFFF (-1), N=1, Z=V=0.
- Sign=1, A=0x80000000, B=0xFFFFFFFF -> Q=0x80000000, R=0, V=1, N=0; same operands with Sign=0 -> Q=0, R=0x80000000, Z=1, V=0.
- A=5, B=0 (either Sign) -> done after 1 edge; Q=0xFFFFFFFF, R=5, DZ=1; then a normal 9/3 completes with Q=3, R=0, DZ=0.
- Start 100/7, assert reset at edge 10 -> busy=done=0 immediately and all outputs 0, no done pulse; a new 50/5 after release gives Q=10, R=0 at full latency; a start pulse during busy is ignored.
- A=3, B=10, Sign=0 -> Q=0, R=3, Z=1; done at edge 1 with ALU_DIV_EARLY_OUT_EN, at edge 34 without.
